// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Sequential control unit for a multicycle MIPS datapath sharing a single
//   instruction/data memory. A Moore FSM walks FETCH / DECODE / EXEC / MEM / WB
//   for every instruction. The memory handshake (mem_ready_i) qualifies the
//   IR/PC write strobes in FETCH and the exits from FETCH and MEM. A consecutive
//   not-ready counter moves the FSM into a sticky HALT (bus error) when memory
//   never answers.
//
// Optional feature macro: MULTICYCLE_CONTROL_JUMP_EN
//   Defined  : J (0x02) / JAL (0x03) are legal, use a JUMP state, and the
//              pc_source_o / link_o ports exist.
//   Undefined: J / JAL are illegal opcodes like any other unsupported one.
//
// Parameters
//   ALUOP_W      ALU op width (>=3); bits above [2:0] are always 0
//   MEM_TIMEOUT  not-ready cycles tolerated before bus error (1..255)
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset; all outputs 0 while low
//   op_i           IR[31:26], valid from DECODE onward
//   mem_ready_i    memory completes the current access this cycle
//   pc_write_o     PC <= ALU result
//   pc_write_eq_o  PC <= branch target if ALU zero
//   pc_write_ne_o  PC <= branch target if ALU not zero
//   ir_write_o     IR <= memory data
//   i_or_d_o       0 = address from PC, 1 = from ALUOut
//   mem_read_o     memory read request
//   mem_write_o    memory write request
//   reg_dst_o      1 = rd, 0 = rt
//   mem_to_reg_o   write-back source: 1 = MDR, 0 = ALUOut
//   reg_write_o    register file write enable
//   alu_src_a_o    0 = PC, 1 = rs
//   alu_src_b_o    0 = rt, 1 = 4, 2 = sign-ext imm, 3 = imm<<2
//   alu_op_o       1 ADD, 2 AND, 3 OR, 4 LUI, 5 SUB, 7 R-type
//   illegal_op_o   one-cycle pulse on an unsupported opcode in DECODE
//   bus_error_o    sticky memory timeout flag; FSM halted
//   instr_done_o   one-cycle pulse on the last cycle of each instruction
//   pc_source_o    (jump build only) 2 = jump target during JUMP
//   link_o         (jump build only) write PC to $31 for JAL
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [5:0]         op_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               pc_write_eq_o,
  output logic               pc_write_ne_o,
  output logic               ir_write_o,
  output logic               i_or_d_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               reg_write_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               illegal_op_o,
  output logic               bus_error_o,
  output logic               instr_done_o
`ifdef MULTICYCLE_CONTROL_JUMP_EN
  ,
  output logic [1:0]         pc_source_o,
  output logic               link_o
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
  localparam logic [2:0] S_JUMP   = 3'd6;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
`endif

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_LUI = 3'd4;
  localparam logic [2:0] ALU_SUB = 3'd5;
  localparam logic [2:0] ALU_R   = 3'd7;

  localparam logic [7:0] STALL_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0] state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [7:0] stall_q, stall_d;
  logic       bus_error_q, bus_error_d;
  logic [2:0] aluOp3;

  // Next-state and output decode. Everything sits under rst_ni so that all
  // strobes fall to 0 combinationally the moment reset is asserted, even
  // though the state register itself resets to FETCH.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    stall_d       = '0;
    bus_error_d   = bus_error_q;
    aluOp3        = 3'd0;
    pc_write_o    = 1'b0;
    pc_write_eq_o = 1'b0;
    pc_write_ne_o = 1'b0;
    ir_write_o    = 1'b0;
    i_or_d_o      = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    reg_dst_o     = 1'b0;
    mem_to_reg_o  = 1'b0;
    reg_write_o   = 1'b0;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = 2'd0;
    illegal_op_o  = 1'b0;
    instr_done_o  = 1'b0;
    bus_error_o   = 1'b0;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
    pc_source_o   = 2'd0;
    link_o        = 1'b0;
`endif
    if (rst_ni) begin
      bus_error_o = bus_error_q;
      case (state_q)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = 2'd1;
          aluOp3      = ALU_ADD;
          if (mem_ready_i) begin
            ir_write_o = 1'b1;
            pc_write_o = 1'b1;
            state_d    = S_DECODE;
          end else if (stall_q == STALL_LAST) begin
            bus_error_d = 1'b1;
            state_d     = S_HALT;
          end else begin
            stall_d = stall_q + 8'd1;
          end
        end
        S_DECODE: begin
          op_d        = op_i;
          alu_src_b_o = 2'd3;
          aluOp3      = ALU_ADD;
          if (op_i inside {OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI,
                           OP_LW, OP_SW, OP_BEQ, OP_BNE}) begin
            state_d = S_EXEC;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
          end else if (op_i == OP_J || op_i == OP_JAL) begin
            state_d = S_JUMP;
`endif
          end else begin
            illegal_op_o = 1'b1;
            instr_done_o = 1'b1;
            state_d      = S_FETCH;
          end
        end
        S_EXEC: begin
          alu_src_a_o = 1'b1;
          case (op_q)
            OP_R: begin
              aluOp3  = ALU_R;
              state_d = S_WB;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
              alu_src_b_o = 2'd2;
              aluOp3      = (op_q == OP_ADDI) ? ALU_ADD :
                            (op_q == OP_ANDI) ? ALU_AND :
                            (op_q == OP_ORI)  ? ALU_OR  : ALU_LUI;
              state_d     = S_WB;
            end
            OP_LW, OP_SW: begin
              alu_src_b_o = 2'd2;
              aluOp3      = ALU_ADD;
              state_d     = S_MEM;
            end
            OP_BEQ, OP_BNE: begin
              aluOp3        = ALU_SUB;
              pc_write_eq_o = (op_q == OP_BEQ);
              pc_write_ne_o = (op_q == OP_BNE);
              instr_done_o  = 1'b1;
              state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
          endcase
        end
        S_MEM: begin
          i_or_d_o    = 1'b1;
          mem_read_o  = (op_q == OP_LW);
          mem_write_o = (op_q != OP_LW);
          if (mem_ready_i) begin
            if (op_q == OP_LW) begin
              state_d = S_WB;
            end else begin
              instr_done_o = 1'b1;
              state_d      = S_FETCH;
            end
          end else if (stall_q == STALL_LAST) begin
            bus_error_d = 1'b1;
            state_d     = S_HALT;
          end else begin
            stall_d = stall_q + 8'd1;
          end
        end
        S_WB: begin
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
          reg_dst_o    = (op_q == OP_R);
          mem_to_reg_o = (op_q == OP_LW);
          state_d      = S_FETCH;
        end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
        S_JUMP: begin
          pc_write_o   = 1'b1;
          pc_source_o  = 2'd2;
          instr_done_o = 1'b1;
          reg_write_o  = (op_q == OP_JAL);
          link_o       = (op_q == OP_JAL);
          state_d      = S_FETCH;
        end
`endif
        S_HALT: state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
    alu_op_o = ALUOP_W'(aluOp3);
  end

  // State, latched opcode, stall counter and sticky bus error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_FETCH;
      op_q        <= 6'd0;
      stall_q     <= 8'd0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      stall_q     <= stall_d;
      bus_error_q <= bus_error_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//   Randomized bench for multicycle_control (default build, no jump support).
//   For every instruction a plan of expected per-cycle output vectors is
//   built from the instruction's opcode and chosen memory stall counts, along
//   with the mem_ready/op values to drive each cycle. The plan is then played
//   against the DUT cycle by cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int TMO = 4;

  typedef struct packed {
    logic       pcw;
    logic       pceq;
    logic       pcne;
    logic       irw;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [3:0] aop;
    logic       ill;
    logic       berr;
    logic       done;
  } outv_t;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [5:0] op = 6'd0;
  logic       memReady = 1'b0;
  logic       pcWrite, pcWriteEq, pcWriteNe, irWrite, iOrD, memRead, memWrite;
  logic       regDst, memToReg, regWrite, aluSrcA, illegalOp, busError, instrDone;
  logic [1:0] aluSrcB;
  logic [3:0] aluOp;
  outv_t      gotV;

  int vecCount = 0;
  int errCount = 0;

  outv_t      expQ[$];
  bit         rdyQ[$];
  logic [5:0] opQ[$];
  string      tagQ[$];

  logic [5:0] legalOps [10] = '{6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0f,
                                6'h23, 6'h2b, 6'h04, 6'h05, 6'h00};

  multicycle_control #(.ALUOP_W(4), .MEM_TIMEOUT(TMO)) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .op_i         (op),
    .mem_ready_i  (memReady),
    .pc_write_o   (pcWrite),
    .pc_write_eq_o(pcWriteEq),
    .pc_write_ne_o(pcWriteNe),
    .ir_write_o   (irWrite),
    .i_or_d_o     (iOrD),
    .mem_read_o   (memRead),
    .mem_write_o  (memWrite),
    .reg_dst_o    (regDst),
    .mem_to_reg_o (memToReg),
    .reg_write_o  (regWrite),
    .alu_src_a_o  (aluSrcA),
    .alu_src_b_o  (aluSrcB),
    .alu_op_o     (aluOp),
    .illegal_op_o (illegalOp),
    .bus_error_o  (busError),
    .instr_done_o (instrDone)
  );

  assign gotV = {pcWrite, pcWriteEq, pcWriteNe, irWrite, iOrD, memRead, memWrite,
                 regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp,
                 illegalOp, busError, instrDone};

  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input outv_t got, input outv_t exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit rdy, input logic [5:0] o);
    rstN     = 1'b1;
    memReady = rdy;
    op       = o;
  endtask

  function automatic bit isLegal(input logic [5:0] o);
    return o inside {6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05};
  endfunction

  task automatic pushCycle(input outv_t e, input bit r, input logic [5:0] o, input string t);
    expQ.push_back(e);
    rdyQ.push_back(r);
    opQ.push_back(o);
    tagQ.push_back(t);
  endtask

  // Memory wait phase: either n stalls then a ready cycle, or a timeout.
  task automatic pushMemPhase(input outv_t e, input outv_t last, input int n,
                              input logic [5:0] o, input bit opRand,
                              input string t, output bit halted);
    outv_t h;
    halted = 1'b0;
    if (n >= TMO) begin
      for (int i = 0; i < TMO; i++)
        pushCycle(e, 1'b0, opRand ? 6'($urandom) : o, {t, "Wait"});
      h = '0;
      h.berr = 1'b1;
      for (int i = 0; i < 3; i++)
        pushCycle(h, 1'($urandom_range(0, 1)), 6'($urandom), "halt");
      halted = 1'b1;
    end else begin
      for (int i = 0; i < n; i++)
        pushCycle(e, 1'b0, opRand ? 6'($urandom) : o, {t, "Wait"});
      pushCycle(last, 1'b1, opRand ? 6'($urandom) : o, t);
    end
  endtask

  // Expected behaviour of one instruction built from the instruction-level
  // rules: fetch, decode, and the opcode-specific remaining steps.
  task automatic buildPlan(input logic [5:0] o, input int nf, input int nm, output bit halted);
    outv_t e, last;
    string sfx;
    sfx = $sformatf(" op=%02h", o);
    e = '0;
    e.mrd = 1'b1;
    e.asb = 2'd1;
    e.aop = 4'd1;
    last = e;
    last.irw = 1'b1;
    last.pcw = 1'b1;
    pushMemPhase(e, last, nf, o, 1'b1, {"fetch", sfx}, halted);
    if (halted) return;

    e = '0;
    e.asb = 2'd3;
    e.aop = 4'd1;
    if (!isLegal(o)) begin
      e.ill  = 1'b1;
      e.done = 1'b1;
    end
    pushCycle(e, 1'($urandom_range(0, 1)), o, {"decode", sfx});
    if (!isLegal(o)) return;

    e = '0;
    e.asa = 1'b1;
    case (o)
      6'h00: e.aop = 4'd7;
      6'h08: begin e.asb = 2'd2; e.aop = 4'd1; end
      6'h0c: begin e.asb = 2'd2; e.aop = 4'd2; end
      6'h0d: begin e.asb = 2'd2; e.aop = 4'd3; end
      6'h0f: begin e.asb = 2'd2; e.aop = 4'd4; end
      6'h23, 6'h2b: begin e.asb = 2'd2; e.aop = 4'd1; end
      6'h04: begin e.aop = 4'd5; e.pceq = 1'b1; e.done = 1'b1; end
      default: begin e.aop = 4'd5; e.pcne = 1'b1; e.done = 1'b1; end
    endcase
    pushCycle(e, 1'($urandom_range(0, 1)), o, {"exec", sfx});
    if (o == 6'h04 || o == 6'h05) return;

    if (o == 6'h23 || o == 6'h2b) begin
      e = '0;
      e.iord = 1'b1;
      e.mrd  = (o == 6'h23);
      e.mwr  = (o == 6'h2b);
      last = e;
      last.done = (o == 6'h2b);
      pushMemPhase(e, last, nm, o, 1'b0, {"mem", sfx}, halted);
      if (halted || o == 6'h2b) return;
    end

    e = '0;
    e.rw   = 1'b1;
    e.done = 1'b1;
    e.rdst = (o == 6'h00);
    e.m2r  = (o == 6'h23);
    pushCycle(e, 1'($urandom_range(0, 1)), o, {"wb", sfx});
  endtask

  // Play up to maxCycles planned cycles: drive just after the rising edge,
  // sample on the falling edge.
  task automatic runPlan(input int maxCycles);
    outv_t      e;
    bit         r;
    logic [5:0] o;
    string      t;
    for (int k = 0; k < maxCycles && expQ.size() > 0; k++) begin
      e = expQ.pop_front();
      r = rdyQ.pop_front();
      o = opQ.pop_front();
      t = tagQ.pop_front();
      @(posedge clk);
      #1;
      applyStimulus(r, o);
      @(negedge clk);
      checkOutput(t, gotV, e);
    end
  endtask

  task automatic clearPlan();
    expQ.delete();
    rdyQ.delete();
    opQ.delete();
    tagQ.delete();
  endtask

  // Assert reset now and check outputs are all zero, immediately and over
  // two further cycles with random inputs. Release happens in runPlan.
  task automatic holdReset(input string t);
    rstN = 1'b0;
    #1;
    checkOutput({t, "Async"}, gotV, '0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      memReady = 1'($urandom_range(0, 1));
      op       = 6'($urandom);
      @(negedge clk);
      checkOutput({t, "Hold"}, gotV, '0);
    end
  endtask

  task automatic runInstr(input logic [5:0] o, input int nf, input int nm);
    bit h;
    buildPlan(o, nf, nm, h);
    runPlan(1000);
    if (h) holdReset("rstAfterHalt");
  endtask

  initial begin
    logic [5:0] o;
    bit         h;

    $display("[TB] start");
    holdReset("rstInit");

    // Directed instructions
    runInstr(6'h00, 0, 0);
    runInstr(6'h23, 0, 3);
    runInstr(6'h05, 0, 0);
    runInstr(6'h3f, 0, 0);
    runInstr(6'h2b, 2, 1);
    runInstr(6'h04, 1, 0);

    // Reset asserted mid-EXEC of an R-type, then a fresh instruction
    buildPlan(6'h00, 0, 0, h);
    runPlan(3);
    clearPlan();
    #1;
    holdReset("rstMidExec");
    runInstr(6'h0d, 0, 0);

    // Randomized instruction stream, stalls kept below the timeout
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        o = legalOps[$urandom_range(0, 9)];
      end else begin
        o = 6'($urandom);
        while (isLegal(o)) o = 6'($urandom);
      end
      runInstr(o, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Timeouts in FETCH and in MEM, each followed by recovery
    runInstr(6'h00, TMO, 0);
    runInstr(6'h08, 0, 0);
    runInstr(6'h2b, 0, TMO);
    runInstr(6'h23, 3, TMO + 2);
    runInstr(6'h00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
